// File: rtl/ara_eoc_pkg.sv
// Shared definitions for the end-of-computation controller: register offsets,
// AXI response codes, FSM state types and a byte-strobe merge helper.
package ara_eoc_pkg;

  localparam int unsigned OffExit    = 'h00;
  localparam int unsigned OffEvent   = 'h08;
  localparam int unsigned OffHwCntEn = 'h10;
  localparam int unsigned OffRuntime = 'h18;
  localparam int unsigned OffScratch = 'h20;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_e;

  typedef enum logic [0:0] {
    StWIdle,
    StWResp
  } wr_state_e;

  typedef enum logic [0:0] {
    StRIdle,
    StRResp
  } rd_state_e;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ara_eoc_sat_counter.sv
// Free-running cycle counter with enable and synchronous clear; sticks at all-ones.
module ara_eoc_sat_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear wins over enable so a restart always begins from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ara_eoc_ctrl.sv
// AXI4-Lite register block that publishes the exit code, VCD trigger word,
// hardware-counter enables and a gated runtime cycle count.
module ara_eoc_ctrl
  import ara_eoc_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter logic [63:0] BaseAddr  = 64'hD000_0000,
  parameter int unsigned NrRegs    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [63:0]            exit_o,
  output logic [63:0]            event_trigger_o,
  output logic [1:0]             hw_cnt_en_o,
  output logic [63:0]            runtime_o
);

  if (DataWidth != 64) begin : gen_dw_check
    $error("ara_eoc_ctrl: DataWidth must be 64");
  end

  localparam logic [AddrWidth-1:0] Base     = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth-1:0] WinBytes = AddrWidth'(NrRegs * 8);

  // Register file
  logic [63:0] exit_q, exit_d;
  logic [63:0] evt_q, evt_d;
  logic [63:0] scratch_q, scratch_d;
  logic [1:0]  cnt_en_q, cnt_en_d;
  logic [63:0] runtime;
  logic        rt_clr;

  // Write channel state
  wr_state_e            wr_state_q, wr_state_d;
  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic [63:0]          w_data_q, w_data_d;
  logic [7:0]           w_strb_q, w_strb_d;
  resp_e                b_resp_q, b_resp_d;

  // Read channel state
  rd_state_e   rd_state_q, rd_state_d;
  logic [63:0] r_data_q, r_data_d;
  resp_e       r_resp_q, r_resp_d;

  // Write decode works on whichever copy (latched or arriving) of AW/W is in play.
  logic [AddrWidth-1:0] wr_addr, wr_off;
  logic [63:0]          wr_data;
  logic [7:0]           wr_strb;
  logic                 wr_err;

  assign wr_addr = aw_held_q ? aw_addr_q : aw_addr_i;
  assign wr_data = w_held_q ? w_data_q : w_data_i;
  assign wr_strb = w_held_q ? w_strb_q : w_strb_i;
  assign wr_off  = wr_addr - Base;
  assign wr_err  = (wr_addr < Base) || (wr_off >= WinBytes) || (wr_addr[2:0] != 3'b000);

  logic [AddrWidth-1:0] rd_off;
  logic                 rd_err;
  logic [63:0]          rd_val;

  assign rd_off = ar_addr_i - Base;
  assign rd_err = (ar_addr_i < Base) || (rd_off >= WinBytes) || (ar_addr_i[2:0] != 3'b000);

  always_comb begin
    rd_val = '0;
    if (rd_off == AddrWidth'(OffExit)) begin
      rd_val = exit_q;
    end else if (rd_off == AddrWidth'(OffEvent)) begin
      rd_val = evt_q;
    end else if (rd_off == AddrWidth'(OffHwCntEn)) begin
      rd_val = {62'b0, cnt_en_q};
    end else if (rd_off == AddrWidth'(OffRuntime)) begin
      rd_val = runtime;
    end else if (rd_off == AddrWidth'(OffScratch)) begin
      rd_val = scratch_q;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    exit_d     = exit_q;
    evt_d      = evt_q;
    scratch_d  = scratch_q;
    cnt_en_d   = cnt_en_q;
    rt_clr     = 1'b0;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;

    unique case (wr_state_q)
      StWIdle: begin
        aw_ready_o = !aw_held_q;
        w_ready_o  = !w_held_q;
        if (aw_valid_i && !aw_held_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = aw_addr_i;
        end
        if (w_valid_i && !w_held_q) begin
          w_held_d = 1'b1;
          w_data_d = w_data_i;
          w_strb_d = w_strb_i;
        end
        if ((aw_held_q || aw_valid_i) && (w_held_q || w_valid_i)) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = StWResp;
          b_resp_d   = RespOkay;
          if (wr_err || (wr_off == AddrWidth'(OffRuntime))) begin
            b_resp_d = RespSlverr;
          end else if (wr_off == AddrWidth'(OffExit)) begin
            // Once done is flagged the exit code is frozen.
            if (!exit_q[0]) exit_d = apply_strb(exit_q, wr_data, wr_strb);
          end else if (wr_off == AddrWidth'(OffEvent)) begin
            evt_d = apply_strb(evt_q, wr_data, wr_strb);
          end else if (wr_off == AddrWidth'(OffHwCntEn)) begin
            if (wr_strb[0]) cnt_en_d = wr_data[1:0];
            rt_clr = !cnt_en_q[0] && cnt_en_d[0];
          end else if (wr_off == AddrWidth'(OffScratch)) begin
            scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
          end
        end
      end
      StWResp: begin
        b_valid_o = 1'b1;
        if (b_ready_i) wr_state_d = StWIdle;
      end
      default: wr_state_d = StWIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;

    unique case (rd_state_q)
      StRIdle: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          rd_state_d = StRResp;
          r_data_d   = rd_err ? '0 : rd_val;
          r_resp_d   = rd_err ? RespSlverr : RespOkay;
        end
      end
      StRResp: begin
        r_valid_o = 1'b1;
        if (r_ready_i) rd_state_d = StRIdle;
      end
      default: rd_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= StWIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RespOkay;
      rd_state_q <= StRIdle;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
      exit_q     <= '0;
      evt_q      <= '0;
      scratch_q  <= '0;
      cnt_en_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
      rd_state_q <= rd_state_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      exit_q     <= exit_d;
      evt_q      <= evt_d;
      scratch_q  <= scratch_d;
      cnt_en_q   <= cnt_en_d;
    end
  end

  ara_eoc_sat_counter #(
    .Width(64)
  ) u_runtime (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (cnt_en_q[0]),
    .clr_i (rt_clr),
    .cnt_o (runtime)
  );

  assign b_resp_o        = b_resp_q;
  assign r_data_o        = r_data_q;
  assign r_resp_o        = r_resp_q;
  assign exit_o          = exit_q;
  assign event_trigger_o = evt_q;
  assign hw_cnt_en_o     = cnt_en_q;
  assign runtime_o       = runtime;

endmodule

// File: tb/tb_ara_eoc_ctrl.sv
// Self-checking bench for ara_eoc_ctrl: directed scenarios plus random register
// traffic compared against a behavioural register-map model.
module tb_ara_eoc_ctrl;

  localparam logic [63:0] Base = 64'hD000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] aw_addr = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [63:0] ar_addr = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [63:0] exit_w, evt_w, runtime_w;
  logic [1:0]  hw_en_w;

  always #5 clk = ~clk;

  ara_eoc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .aw_addr_i      (aw_addr),
    .aw_valid_i     (aw_valid),
    .aw_ready_o     (aw_ready),
    .w_data_i       (w_data),
    .w_strb_i       (w_strb),
    .w_valid_i      (w_valid),
    .w_ready_o      (w_ready),
    .b_resp_o       (b_resp),
    .b_valid_o      (b_valid),
    .b_ready_i      (b_ready),
    .ar_addr_i      (ar_addr),
    .ar_valid_i     (ar_valid),
    .ar_ready_o     (ar_ready),
    .r_data_o       (r_data),
    .r_resp_o       (r_resp),
    .r_valid_o      (r_valid),
    .r_ready_i      (r_ready),
    .exit_o         (exit_w),
    .event_trigger_o(evt_w),
    .hw_cnt_en_o    (hw_en_w),
    .runtime_o      (runtime_w)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  longint      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents plus the edges at which counting last
  // started (m_a) and stopped (m_d), numbered by cyc.
  logic [63:0] m_exit, m_evt, m_scr;
  logic [1:0]  m_en;
  longint      m_a, m_d;

  function automatic void model_reset();
    m_exit = '0; m_evt = '0; m_scr = '0; m_en = '0; m_a = 0; m_d = 0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic dec_err(input logic [63:0] a);
    return (a < Base) || ((a - Base) >= 64'd64) || (a[2:0] != 3'b000);
  endfunction

  // Runtime value held after edge k.
  function automatic logic [63:0] rt_after(input longint k);
    return m_en[0] ? 64'(k - m_a) : 64'(m_d - m_a);
  endfunction

  function automatic logic [1:0] model_write(input logic [63:0] a, input logic [63:0] d,
                                             input logic [7:0] s, input longint e);
    logic [1:0] nb;
    if (dec_err(a)) return 2'b10;
    case (int'((a - Base) >> 3))
      0: if (!m_exit[0]) m_exit = merge(m_exit, d, s);
      1: m_evt = merge(m_evt, d, s);
      2: if (s[0]) begin
        nb = d[1:0];
        if (!m_en[0] && nb[0]) m_a = e;
        if (m_en[0] && !nb[0]) m_d = e;
        m_en = nb;
      end
      3: return 2'b10;
      4: m_scr = merge(m_scr, d, s);
      default: ;
    endcase
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [63:0] a, input longint k,
                                     output logic [63:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    if (dec_err(a)) begin
      r = 2'b10;
      return;
    end
    case (int'((a - Base) >> 3))
      0: d = m_exit;
      1: d = m_evt;
      2: d = {62'b0, m_en};
      3: d = rt_after(k);
      4: d = m_scr;
      default: d = '0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
    check_eq({tag, "_w_ready"}, 64'(w_ready), 64'd1);
    check_eq({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
    check_eq({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    check_eq({tag, "_b_resp"}, 64'(b_resp), 64'd0);
    check_eq({tag, "_r_valid"}, 64'(r_valid), 64'd0);
    check_eq({tag, "_r_data"}, r_data, 64'd0);
    check_eq({tag, "_r_resp"}, 64'(r_resp), 64'd0);
    check_eq({tag, "_exit"}, exit_w, 64'd0);
    check_eq({tag, "_event"}, evt_w, 64'd0);
    check_eq({tag, "_hw_en"}, 64'(hw_en_w), 64'd0);
    check_eq({tag, "_runtime"}, runtime_w, 64'd0);
  endtask

  task automatic do_reset();
    aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // W is presented w_lead cycles ahead of AW (0 = same cycle); the response is
  // then held off for b_delay cycles. e returns the edge on which the write lands.
  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int w_lead, input int b_delay,
                           output logic [1:0] resp, output longint e);
    int t;
    resp = 2'b11;
    aw_addr = a; w_data = d; w_strb = s; w_valid = 1;
    if (w_lead > 0) begin
      @(negedge clk);
      check_eq("w_ready_idle", 64'(w_ready), 64'd1);
      @(posedge clk);
      #1 w_valid = 0;
      for (int i = 1; i < w_lead; i++) begin
        @(negedge clk);
        check_eq("w_ready_after_w", 64'(w_ready), 64'd0);
        @(posedge clk);
        #1;
      end
    end
    aw_valid = 1;
    @(negedge clk);
    check_eq("aw_ready_idle", 64'(aw_ready), 64'd1);
    check_eq("w_ready_at_aw", 64'(w_ready), (w_lead > 0) ? 64'd0 : 64'd1);
    @(posedge clk);
    #1;
    e = cyc;
    aw_valid = 0; w_valid = 0;
    @(negedge clk);
    check_eq("b_valid_latency", 64'(b_valid), 64'd1);
    t = 0;
    while (!b_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!b_valid) begin
      check_eq("b_valid_timeout", 64'(b_valid), 64'd1);
      return;
    end
    resp = b_resp;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check_eq("b_valid_stable", 64'(b_valid), 64'd1);
      check_eq("b_resp_stable", 64'(b_resp), 64'(resp));
      check_eq("aw_ready_busy", 64'(aw_ready), 64'd0);
    end
    b_ready = 1;
    @(posedge clk);
    #1 b_ready = 0;
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp,
                          output longint re);
    int t;
    d = '0;
    resp = 2'b11;
    ar_addr = a; ar_valid = 1;
    @(negedge clk);
    check_eq("ar_ready_idle", 64'(ar_ready), 64'd1);
    @(posedge clk);
    #1;
    re = cyc;
    ar_valid = 0;
    @(negedge clk);
    check_eq("r_valid_latency", 64'(r_valid), 64'd1);
    check_eq("ar_ready_busy", 64'(ar_ready), 64'd0);
    t = 0;
    while (!r_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!r_valid) begin
      check_eq("r_valid_timeout", 64'(r_valid), 64'd1);
      return;
    end
    d = r_data;
    resp = r_resp;
    r_ready = 1;
    @(posedge clk);
    #1 r_ready = 0;
  endtask

  task automatic wr_chk(input string tag, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input int lead, input int bd);
    logic [1:0] resp;
    longint     e;
    axi_write(a, d, s, lead, bd, resp, e);
    check_eq({tag, "_bresp"}, 64'(resp), 64'(model_write(a, d, s, e)));
    check_eq({tag, "_exit"}, exit_w, m_exit);
    check_eq({tag, "_event"}, evt_w, m_evt);
    check_eq({tag, "_hw_en"}, 64'(hw_en_w), 64'(m_en));
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] a);
    logic [63:0] d, ed;
    logic [1:0]  resp, er;
    longint      re;
    axi_read(a, d, resp, re);
    model_read(a, re - 1, ed, er);
    check_eq({tag, "_rresp"}, 64'(resp), 64'(er));
    check_eq({tag, "_rdata"}, d, ed);
  endtask

  logic [63:0] rand_addrs [10];

  initial begin
    logic [63:0] d, old;
    logic [1:0]  resp;
    longint      re, e;
    int          t;

    rand_addrs = '{Base, Base + 8, Base + 16, Base + 24, Base + 32, Base + 40, Base + 56,
                   Base + 4, Base + 64, Base - 8};

    do_reset();
    check_reset_outputs("reset");

    // Done flag with AW and W together.
    wr_chk("exit_done", Base, 64'h1, 8'hFF, 0, 0);
    check_eq("exit_done_lit", exit_w, 64'h1);

    // W two cycles ahead of AW, then a sticky-exit overwrite attempt.
    do_reset();
    wr_chk("exit_code", Base, 64'h7, 8'hFF, 2, 0);
    check_eq("exit_code_lit", exit_w, 64'h7);
    wr_chk("exit_sticky", Base, 64'h1, 8'hFF, 0, 0);
    check_eq("exit_sticky_lit", exit_w, 64'h7);

    // Gated runtime counter.
    wr_chk("cnt_on", Base + 64'h10, 64'h1, 8'h01, 0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check_eq("runtime_live", runtime_w, rt_after(cyc));
    @(posedge clk);
    #1;
    wr_chk("cnt_off", Base + 64'h10, 64'h0, 8'h01, 0, 0);
    rd_chk("runtime_frozen", Base + 64'h18);
    check_eq("runtime_hold", runtime_w, rt_after(cyc));
    wr_chk("cnt_on2", Base + 64'h10, 64'h3, 8'h01, 0, 0);
    check_eq("runtime_restart", runtime_w, rt_after(cyc));
    rd_chk("runtime_restart_rd", Base + 64'h18);

    // Decode errors and reserved space.
    rd_chk("rd_misaligned", Base + 64'h4);
    rd_chk("rd_outside", Base + 64'h40);
    wr_chk("wr_runtime", Base + 64'h18, 64'h5, 8'hFF, 0, 0);
    rd_chk("rd_reserved", Base + 64'h30);

    // Partial strobe over a zero SCRATCH.
    wr_chk("scr_strb", Base + 64'h20, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 0, 0);
    axi_read(Base + 64'h20, d, resp, re);
    check_eq("scr_strb_lit", d, 64'h0000_0000_EEFF_0011);

    // Same-cycle read and write of SCRATCH returns the old value.
    old = m_scr;
    aw_addr = Base + 64'h20; w_data = 64'h1234_5678_9ABC_DEF0; w_strb = 8'hFF;
    ar_addr = Base + 64'h20;
    aw_valid = 1; w_valid = 1; ar_valid = 1;
    @(posedge clk);
    #1;
    e = cyc;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    @(negedge clk);
    check_eq("rw_b_valid", 64'(b_valid), 64'd1);
    check_eq("rw_r_valid", 64'(r_valid), 64'd1);
    check_eq("rw_old_data", r_data, old);
    check_eq("rw_bresp", 64'(b_resp), 64'(model_write(Base + 64'h20, w_data, 8'hFF, e)));
    b_ready = 1; r_ready = 1;
    @(posedge clk);
    #1 b_ready = 0; r_ready = 0;
    rd_chk("rw_new_data", Base + 64'h20);

    // Backpressure on B.
    wr_chk("bp_event", Base + 64'h8, 64'hDEAD_BEEF_0000_0042, 8'hFF, 1, 5);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      a = rand_addrs[$urandom_range(9, 0)];
      if ($urandom_range(1, 0) == 1) begin
        wr_chk("rnd_wr", a, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(2, 0)),
               int'($urandom_range(2, 0)));
      end else begin
        rd_chk("rnd_rd", a);
      end
    end

    // Reset in the middle of a held-off write response.
    aw_addr = Base + 64'h20; w_data = 64'hFFFF; w_strb = 8'hFF;
    aw_valid = 1; w_valid = 1;
    @(posedge clk);
    #1 aw_valid = 0; w_valid = 0;
    t = 0;
    while (!b_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_b_valid", 64'(b_valid), 64'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    b_ready = 1;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_replay", 64'(b_valid), 64'd0);
    end
    b_ready = 0;
    @(posedge clk);
    #1;
    rd_chk("post_reset_scr", Base + 64'h20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
